segment_calc_scheduler: RTL and testbench
=========================================

# segment_calc_scheduler

Sequencer that time-shares one segment calculation unit of the modulation pipe across `NUM_SEG` segments. On `start` it latches the frame's `input_bit`/`zero` words and picks the then- or else-branch for each segment. It issues one calculation per segment over a start/valid/busy handshake and streams each segment result out with its index. After the last segment it pulses a frame-level `valid`.

## Interface
- `WIDTH`, 32, data and control word width
- `NUM_SEG`, 16, segments per frame (2..WIDTH)
- `IW`, $clog2(NUM_SEG), index width
- `TIMEOUT`, 64, max cycles waited for `seg_valid` per segment (≥2)

- `clk` in 1, the single clock; all state updates on its rising edge
- `reset` in 1, asynchronous, active-low; clears all state
- `start` in 1, frame request; honoured only in IDLE
- `input_bit` in WIDTH, per-segment branch bits; latched on accepted start
- `zero` in WIDTH, per-segment reference bits; latched on accepted start
- `seg_idx` out IW, segment index presented to the calc unit
- `seg_sel` out 1, 0 = then-branch (array_ref), 1 = else-branch (array_ref_m)
- `seg_start` out 1, one-cycle issue pulse to the calc unit
- `seg_busy` in 1, calc unit cannot accept an issue
- `seg_valid` in 1, calc unit result strobe
- `seg_data` in WIDTH, calc unit result
- `out_data` out WIDTH, captured segment result
- `out_idx` out IW, index of `out_data`
- `out_valid` out 1, one-cycle strobe per captured segment
- `valid` out 1, one-cycle frame-complete strobe
- `busy` out 1, high whenever state ≠ IDLE
- `err` out 1, sticky timeout flag; cleared on the next accepted start

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE, on `start`:
  - latch `input_bit` and `zero`
  - idx←0, `err`←0
  - go to ISSUE
- ISSUE:
  - `seg_start` = !`seg_busy` (combinational from state).
  - If `seg_busy` is high, stay in ISSUE with no pulse. Stall is unbounded.
  - Otherwise go to WAIT and clear the timer.
- `seg_idx` = idx at all times.
- `seg_sel` = (latched `input_bit`[idx] != latched `zero`[idx]).
- WAIT, on `seg_valid`:
  - `out_data`←`seg_data`, `out_idx`←idx, `out_valid`←1 for one cycle.
  - If idx = NUM_SEG−1, go to DONE. Otherwise idx←idx+1 and go to ISSUE.
- WAIT, no `seg_valid`: timer increments.
  - When timer = TIMEOUT−1: `err`←1, abandon the remaining segments, go to DONE.
  - If `seg_valid` arrives in the same cycle, it wins: the result is captured and there is no error.
- DONE: `valid`=1 for exactly one cycle, then return to IDLE. `valid` also fires on an aborted frame (`err`=1).
- `seg_valid` outside WAIT is ignored; no `out_valid` is generated.
- `start` outside IDLE is ignored, including in the DONE cycle.
- idx never exceeds NUM_SEG−1. The timer saturates and does not wrap.

## Timing
- Reset values:
  - state IDLE, idx 0, timer 0
  - `seg_start` 0, `seg_sel` 0, `seg_idx` 0
  - `out_data` 0, `out_idx` 0, `out_valid` 0
  - `valid` 0, `busy` 0, `err` 0
- Reset asserted mid-frame: all of the above apply immediately (asynchronously). Any result still in flight in the calc unit is dropped.
- Cycle 0 is the edge that samples `start`. ISSUE is entered in cycle 1.
- Calc-unit latency L is the number of cycles from the `seg_start` cycle to the `seg_valid` cycle (L≥1). With no stalls:
  - segment k is issued in cycle 1+k(L+1)
  - `out_valid` for segment k is high in cycle 1+k(L+1)+L+1
  - `valid` is high in cycle NUM_SEG(L+1)+1
  - the next `start` is accepted one cycle after that
- Each stall cycle on `seg_busy` delays all later events by one cycle.

## Test plan
- NUM_SEG=16, L=1, `input_bit`=0x0000_00F0, `zero`=0 -> `seg_sel`=1 for idx 4..7 only; 16 `out_valid` strobes with `out_idx` 0..15 in order; `valid` in cycle 33; `err`=0.
- Hold `seg_busy` high for 5 cycles during segment 3 issue -> no `seg_start` during the stall; `valid` arrives 5 cycles later than nominal; data order unchanged.
- Never return `seg_valid` for segment 2 (TIMEOUT=64) -> `err`=1 after 64 WAIT cycles; `out_valid` count = 2; `valid` pulses once; next `start` clears `err`.
- `seg_valid` on the exact timeout cycle -> result captured, `err`=0, frame continues.
- `start` pulsed in WAIT and in the DONE cycle, plus a spurious `seg_valid` in IDLE -> all ignored; no extra strobes.
- Drive `reset` low during segment 7 -> all outputs 0 immediately; a following `start` runs a full frame from idx 0.

Source files
------------

// File: rtl/segment_calc_scheduler.sv
// Frame sequencer that time-shares one segment calculation unit across NUM_SEG segments,
// issuing one calculation per segment and streaming each result out with its index.
module segment_calc_scheduler #(
    parameter int WIDTH   = 32,
    parameter int NUM_SEG = 16,
    parameter int IW      = $clog2(NUM_SEG),
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] input_bit,
    input  logic [WIDTH-1:0] zero,
    output logic [IW-1:0]    seg_idx,
    output logic             seg_sel,
    output logic             seg_start,
    input  logic             seg_busy,
    input  logic             seg_valid,
    input  logic [WIDTH-1:0] seg_data,
    output logic [WIDTH-1:0] out_data,
    output logic [IW-1:0]    out_idx,
    output logic             out_valid,
    output logic             valid,
    output logic             busy,
    output logic             err
);

    localparam int              TW         = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [IW-1:0]   LAST_IDX   = IW'(NUM_SEG - 1);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t               state_reg, state_next;
    logic [IW-1:0]        idx_reg, idx_next;
    logic [TW-1:0]        timer_reg, timer_next;
    logic [NUM_SEG-1:0]   branch_reg, branch_next;
    logic [NUM_SEG-1:0]   branch_in;
    logic [WIDTH-1:0]     out_data_reg, out_data_next;
    logic [IW-1:0]        out_idx_reg, out_idx_next;
    logic                 out_valid_reg, out_valid_next;
    logic                 err_reg, err_next;

    // Only the branch decision per segment matters later, so the two words are
    // folded into one else-branch mask when the frame is accepted.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SEG; gi++) begin : g_branch
            assign branch_in[gi] = input_bit[gi] ^ zero[gi];
        end
        if (NUM_SEG < WIDTH) begin : g_spare
            logic unused_hi;
            assign unused_hi = ^{input_bit[WIDTH-1:NUM_SEG], zero[WIDTH-1:NUM_SEG]};
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            timer_reg     <= '0;
            branch_reg    <= '0;
            out_data_reg  <= '0;
            out_idx_reg   <= '0;
            out_valid_reg <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            timer_reg     <= timer_next;
            branch_reg    <= branch_next;
            out_data_reg  <= out_data_next;
            out_idx_reg   <= out_idx_next;
            out_valid_reg <= out_valid_next;
            err_reg       <= err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        timer_next     = timer_reg;
        branch_next    = branch_reg;
        out_data_next  = out_data_reg;
        out_idx_next   = out_idx_reg;
        out_valid_next = 1'b0;
        err_next       = err_reg;
        seg_start      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    branch_next = branch_in;
                    idx_next    = '0;
                    err_next    = 1'b0;
                    state_next  = ISSUE;
                end
            end
            ISSUE: begin
                if (!seg_busy) begin
                    seg_start  = 1'b1;
                    timer_next = '0;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                // A result arriving on the timeout cycle takes priority over the abort.
                if (seg_valid) begin
                    out_data_next  = seg_data;
                    out_idx_next   = idx_reg;
                    out_valid_next = 1'b1;
                    if (idx_reg == LAST_IDX) begin
                        state_next = DONE;
                    end else begin
                        idx_next   = idx_reg + IW'(1);
                        state_next = ISSUE;
                    end
                end else if (timer_reg == TIMER_LAST) begin
                    err_next   = 1'b1;
                    state_next = DONE;
                end else begin
                    timer_next = timer_reg + TW'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign seg_idx   = idx_reg;
    assign seg_sel   = branch_reg[idx_reg];
    assign out_data  = out_data_reg;
    assign out_idx   = out_idx_reg;
    assign out_valid = out_valid_reg;
    assign valid     = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign err       = err_reg;

endmodule

// File: tb/tb_segment_calc_scheduler.sv
// Scoreboard bench for segment_calc_scheduler: an in-bench calc unit answers issues,
// directed frames push expected strobes, and a monitor pops and compares them.
module tb_segment_calc_scheduler;

    localparam int WIDTH   = 32;
    localparam int NUM_SEG = 16;
    localparam int IW      = 4;
    localparam int TIMEOUT = 64;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] input_bit = '0;
    logic [WIDTH-1:0] zero = '0;
    logic [IW-1:0]    seg_idx;
    logic             seg_sel;
    logic             seg_start;
    logic             seg_busy = 1'b0;
    logic             seg_valid = 1'b0;
    logic [WIDTH-1:0] seg_data = '0;
    logic [WIDTH-1:0] out_data;
    logic [IW-1:0]    out_idx;
    logic             out_valid;
    logic             valid;
    logic             busy;
    logic             err;

    segment_calc_scheduler #(
        .WIDTH(WIDTH), .NUM_SEG(NUM_SEG), .IW(IW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .input_bit(input_bit), .zero(zero),
        .seg_idx(seg_idx), .seg_sel(seg_sel), .seg_start(seg_start), .seg_busy(seg_busy),
        .seg_valid(seg_valid), .seg_data(seg_data), .out_data(out_data), .out_idx(out_idx),
        .out_valid(out_valid), .valid(valid), .busy(busy), .err(err)
    );

    typedef struct { int idx; logic [31:0] data; int cyc; } out_t;
    typedef struct { int cyc; logic err; int cnt; } frm_t;

    out_t out_q[$];
    frm_t frm_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int frame_base = 0;
    int out_cnt = 0;

    // calc-unit behaviour knobs
    int lat = 1;
    int stall_seg = -1;
    int stall_len = 0;
    int stall_cnt = 0;
    int drop_seg = -1;
    int late_seg = -1;
    int late_lat = 1;
    bit spurious = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mk_data(int idx, logic sel);
        return 32'hC0DE_0000 | (sel ? 32'h0000_0100 : 32'h0) | 32'(idx);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Segment k of an unstalled L=1 frame strobes out_valid in cycle 2k+3.
    task automatic expect_frame(logic [31:0] ib, logic [31:0] zr, int nout,
                                int shift_from, int shift_amt, int vcyc, logic e);
        out_t o;
        frm_t f;
        for (int k = 0; k < nout; k++) begin
            o.idx  = k;
            o.data = mk_data(k, ib[k] ^ zr[k]);
            o.cyc  = 2 * k + 3 + ((k >= shift_from) ? shift_amt : 0);
            out_q.push_back(o);
        end
        f.cyc = vcyc;
        f.err = e;
        f.cnt = nout;
        frm_q.push_back(f);
    endtask

    // Returns at the falling edge inside cycle 1 (first ISSUE cycle).
    task automatic pulse_start(logic [31:0] ib, logic [31:0] zr);
        @(negedge clk);
        input_bit  = ib;
        zero       = zr;
        start      = 1'b1;
        frame_base = cyc;
        out_cnt    = 0;
        @(negedge clk);
        start     = 1'b0;
        input_bit = $urandom;
        zero      = $urandom;
    endtask

    task automatic wait_done(string name);
        int n;
        n = 0;
        while (frm_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (frm_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s_frame_timeout: valid not seen after %0d cycles, required within 400", name, n);
            frm_q.delete();
            out_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Monitor: pops the scoreboard on every strobe.
    initial begin
        out_t o;
        frm_t f;
        forever begin
            @(negedge clk);
            if (reset && out_valid) begin
                out_cnt++;
                $display("out   idx=%0d data=0x%08h cycle=%0d", out_idx, out_data, cyc - frame_base);
                if (out_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL out_unexpected: out_valid with idx=%0d data=0x%0h, required no strobe", out_idx, out_data);
                end else begin
                    o = out_q.pop_front();
                    check("out_idx", 32'(out_idx), 32'(o.idx));
                    check("out_data", out_data, o.data);
                    check("out_cycle", 32'(cyc - frame_base), 32'(o.cyc));
                end
            end
            if (reset && valid) begin
                $display("frame valid cycle=%0d err=%0d outs=%0d", cyc - frame_base, err, out_cnt);
                if (frm_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL valid_unexpected: frame valid at cycle %0d, required no strobe", cyc - frame_base);
                end else begin
                    f = frm_q.pop_front();
                    check("valid_cycle", 32'(cyc - frame_base), 32'(f.cyc));
                    check("frame_err", 32'(err), 32'(f.err));
                    check("frame_out_count", 32'(out_cnt), 32'(f.cnt));
                end
            end
        end
    end

    // Calc unit model: answers each issue after its latency, can stall or stay silent.
    initial begin
        bit          pending;
        int          resp_at;
        logic [31:0] resp_data;
        pending = 1'b0;
        resp_at = 0;
        resp_data = '0;
        forever begin
            @(negedge clk);
            seg_valid = 1'b0;
            if (!reset) begin
                pending  = 1'b0;
                seg_busy = 1'b0;
            end else begin
                if (spurious) begin
                    seg_valid = 1'b1;
                    seg_data  = 32'hDEAD_BEEF;
                    spurious  = 1'b0;
                end else if (pending && cyc == resp_at) begin
                    seg_valid = 1'b1;
                    seg_data  = resp_data;
                    pending   = 1'b0;
                end
                seg_busy = 1'b0;
                if (busy && stall_seg >= 0 && int'(seg_idx) == stall_seg && stall_cnt < stall_len) begin
                    seg_busy = 1'b1;
                    stall_cnt++;
                end
                #1;
                if (seg_busy) check("no_issue_while_busy", 32'(seg_start), 32'd0);
                if (seg_start && int'(seg_idx) != drop_seg) begin
                    pending   = 1'b1;
                    resp_at   = cyc + ((int'(seg_idx) == late_seg) ? late_lat : lat);
                    resp_data = mk_data(int'(seg_idx), seg_sel);
                end
            end
        end
    end

    initial begin
        int n;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_seg_start", 32'(seg_start), 32'd0);
        check("rst_seg_idx", 32'(seg_idx), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Nominal frame, else-branch on segments 4..7 only.
        expect_frame(32'h0000_00F0, 32'h0, 16, 16, 0, 33, 1'b0);
        pulse_start(32'h0000_00F0, 32'h0);
        wait_done("nominal");

        // Five busy cycles on segment 3 issue shift everything after by five.
        stall_seg = 3; stall_len = 5; stall_cnt = 0;
        expect_frame(32'h0000_A5A5, 32'h0000_0FF0, 16, 3, 5, 38, 1'b0);
        pulse_start(32'h0000_A5A5, 32'h0000_0FF0);
        wait_done("stall");
        stall_seg = -1;

        // Segment 2 never answers: abort after 64 WAIT cycles.
        drop_seg = 2;
        expect_frame(32'h1234_5678, 32'h0000_FFFF, 2, 16, 0, 70, 1'b1);
        pulse_start(32'h1234_5678, 32'h0000_FFFF);
        wait_done("timeout");
        drop_seg = -1;
        check("err_sticky", 32'(err), 32'd1);
        check("idle_after_abort", 32'(busy), 32'd0);
        expect_frame(32'h0000_8001, 32'h0000_0001, 16, 16, 0, 33, 1'b0);
        pulse_start(32'h0000_8001, 32'h0000_0001);
        check("err_cleared_by_start", 32'(err), 32'd0);
        wait_done("after_timeout");

        // Answer lands on the timeout cycle: captured, no error, frame continues.
        late_seg = 2; late_lat = 64;
        expect_frame(32'h0000_F00F, 32'h0000_00FF, 16, 2, 63, 96, 1'b0);
        pulse_start(32'h0000_F00F, 32'h0000_00FF);
        wait_done("exact_timeout");
        late_seg = -1;

        // start in WAIT and in DONE, stray seg_valid in IDLE: all ignored.
        expect_frame(32'h0000_3C3C, 32'h0000_0F0F, 16, 16, 0, 33, 1'b0);
        pulse_start(32'h0000_3C3C, 32'h0000_0F0F);
        n = 0;
        do begin @(negedge clk); n++; end while (!(busy && !seg_start && !valid) && n < 50);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!valid && n < 100) begin @(negedge clk); n++; end
        check("done_reached", 32'(valid), 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_in_done_ignored", 32'(busy), 32'd0);
        spurious = 1'b1;
        repeat (4) @(negedge clk);
        check("spurious_out_count", 32'(out_cnt), 32'd16);
        check("spurious_busy", 32'(busy), 32'd0);

        // Asynchronous reset during segment 7.
        expect_frame(32'h0000_00F0, 32'h0, 16, 16, 0, 33, 1'b0);
        pulse_start(32'h0000_00F0, 32'h0);
        n = 0;
        while (!(busy && seg_idx == 4'd7) && n < 100) begin @(negedge clk); n++; end
        check("reached_seg7", 32'(seg_idx), 32'd7);
        #2 reset = 1'b0;
        #1;
        check("arst_seg_start", 32'(seg_start), 32'd0);
        check("arst_seg_sel", 32'(seg_sel), 32'd0);
        check("arst_seg_idx", 32'(seg_idx), 32'd0);
        check("arst_out_data", out_data, 32'd0);
        check("arst_out_idx", 32'(out_idx), 32'd0);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_valid", 32'(valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_err", 32'(err), 32'd0);
        out_q.delete();
        frm_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        expect_frame(32'h0000_5555, 32'h0000_00FF, 16, 16, 0, 33, 1'b0);
        pulse_start(32'h0000_5555, 32'h0000_00FF);
        wait_done("after_reset");

        check("out_queue_drained", 32'(out_q.size()), 32'd0);
        check("frame_queue_drained", 32'(frm_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
